seq_detect_ctrl: RTL
====================

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 SHALL have parameter PAT_W, default 8, max pattern length in bits (2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of match counter and target.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cfg_we  input  1  load configuration (honoured in IDLE only).
REQ-006 SHALL have port cfg_pattern  input  PAT_W  pattern; bit 0 = most recent serial bit.
REQ-007 SHALL have port cfg_len  input  5  pattern length in bits, valid 1..PAT_W.
REQ-008 SHALL have port cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping.
REQ-009 SHALL have port cfg_target  input  CNT_W  matches before done; 0 = unlimited.
REQ-010 SHALL have port start  input  1  arm detection.
REQ-011 SHALL have port abort  input  1  stop detection.
REQ-012 SHALL have port x  input  1  serial data bit.
REQ-013 SHALL have port x_valid  input  1  x is sampled this cycle.
REQ-014 SHALL have port z  output  1  registered one-cycle match pulse.
REQ-015 SHALL have port match_cnt  output  CNT_W  matches since last start.
REQ-016 SHALL have port busy  output  1  high in RUN.
REQ-017 SHALL have port done  output  1  high in DONE.
REQ-018 SHALL have port err  output  1  one-cycle pulse on start with invalid config.

Function
REQ-019 SHALL implement states IDLE, RUN, DONE; busy = (RUN), done = (DONE), both registered.
REQ-020 SHALL latch cfg_* into internal registers on cfg_we in IDLE; cfg_we in RUN/DONE ignored.
REQ-021 SHALL, on start in IDLE with latched len in 1..PAT_W: go to RUN next cycle; clear history, bits_seen, match_cnt.
REQ-022 SHALL, on start in IDLE with len 0 or > PAT_W: stay IDLE, pulse err next cycle, leave match_cnt unchanged.
REQ-023 SHALL, in RUN on x_valid, shift history {hist[PAT_W-2:0], x}; bits_seen increments, saturating at len.
REQ-024 SHALL declare a match when post-shift bits_seen >= len and low len bits of history equal low len bits of pattern.
REQ-025 SHALL pulse z the cycle after the matching x_valid cycle; match_cnt increments on the same edge, saturating at all-ones.
REQ-026 SHALL, when cfg_overlap = 0, clear bits_seen to 0 on a match, so no bits are shared between matches.
REQ-027 SHALL, when target != 0 and match_cnt reaches target, enter DONE on the same edge as the final z pulse.
REQ-028 SHALL ignore x_valid in IDLE and DONE; z stays 0 there.
REQ-029 SHALL, on abort in RUN or DONE, return to IDLE next cycle, hold match_cnt, and suppress z for that cycle.
REQ-030 SHALL give abort priority over start when both are asserted; start in RUN is ignored.
REQ-031 SHALL treat start in DONE as a restart into RUN, validated as in REQ-021/022.
REQ-032 SHALL keep match_cnt stable outside RUN until the next valid start.

Reset
REQ-033 SHALL, on rst high at a clock edge, force IDLE: z=0, busy=0, done=0, err=0, match_cnt=0, history=0, bits_seen=0.
REQ-034 SHALL reset latched config to pattern=0, len=1, overlap=1, target=0.
REQ-035 SHALL let rst override start, abort, cfg_we and x_valid, including mid-RUN.

Verification
REQ-036 SHALL cover: pattern 3'b111, len 3, overlap 1, target 0; x = 1,0,1,1,1,0,0,1,1,1 -> z after 5th and 10th bits, match_cnt=2, busy=1.
REQ-037 SHALL cover: pattern 4'b1111, len 4, six consecutive 1s -> overlap 1: match_cnt=3; overlap 0: match_cnt=1.
REQ-038 SHALL cover: pattern 2'b10, len 2, target 2; x = 1,0,1,0,1,0 -> DONE after 4th bit, match_cnt=2, 5th/6th bits ignored.
REQ-039 SHALL cover: len 0 then start -> err one cycle, busy stays 0; len 9 with PAT_W=8 -> same.
REQ-040 SHALL cover: abort and start asserted together in RUN after 1 match -> IDLE next cycle, match_cnt=1, no z.
REQ-041 SHALL cover: rst mid-RUN with 2 of 3 pattern bits received -> all outputs 0; restart needs 3 new bits for a match.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - configurable serial pattern detector with match counting and run control
module seq_detect_ctrl #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [4:0]       cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             abort,
    input  logic             x,
    input  logic             x_valid,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] PAT_LEN_MAX = 5'(PAT_W);

    state_t state;

    // Configuration latched while idle; detection always works from these copies.
    logic [PAT_W-1:0] pat_q;
    logic [4:0]       len_q;
    logic             ovl_q;
    logic [CNT_W-1:0] tgt_q;

    // Serial history (bit 0 = newest) and number of bits usable for the next match.
    logic [PAT_W-1:0] hist;
    logic [4:0]       bits_seen;

    logic             len_ok;
    logic [PAT_W-1:0] len_mask;
    logic [PAT_W-1:0] hist_n;
    logic [4:0]       seen_n;
    logic             hit;
    logic [CNT_W-1:0] cnt_inc;
    logic             tgt_hit;

    // Length check and a mask selecting the low len bits of history/pattern.
    always_comb begin
        len_ok   = (len_q != 5'd0) && (len_q <= PAT_LEN_MAX);
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (5'(i) < len_q);
        end
    end

    // Post-shift view of the detector: new history, saturated bit count, match and counter update.
    always_comb begin
        hist_n  = {hist[PAT_W-2:0], x};
        seen_n  = (bits_seen >= len_q) ? len_q : bits_seen + 5'd1;
        hit     = (seen_n >= len_q) && (((hist_n ^ pat_q) & len_mask) == '0);
        cnt_inc = (&match_cnt) ? match_cnt : match_cnt + CNT_W'(1);
        tgt_hit = (tgt_q != '0) && (cnt_inc == tgt_q);
    end

    // Control FSM with registered outputs; z and err are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            z         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            match_cnt <= '0;
            hist      <= '0;
            bits_seen <= 5'd0;
            pat_q     <= '0;
            len_q     <= 5'd1;
            ovl_q     <= 1'b1;
            tgt_q     <= '0;
        end else begin
            z   <= 1'b0;
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_we) begin
                        pat_q <= cfg_pattern;
                        len_q <= cfg_len;
                        ovl_q <= cfg_overlap;
                        tgt_q <= cfg_target;
                    end
                    // Abort wins over start; start uses the already-latched length.
                    if (start && !abort) begin
                        if (len_ok) begin
                            state     <= S_RUN;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            hist      <= '0;
                            bits_seen <= 5'd0;
                            match_cnt <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (x_valid) begin
                        hist <= hist_n;
                        if (hit) begin
                            z         <= 1'b1;
                            match_cnt <= cnt_inc;
                            // Non-overlapping mode starts the next match from scratch.
                            bits_seen <= ovl_q ? seen_n : 5'd0;
                            if (tgt_hit) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            bits_seen <= seen_n;
                        end
                    end
                end

                S_DONE: begin
                    if (abort) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end else if (start) begin
                        if (len_ok) begin
                            state     <= S_RUN;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            hist      <= '0;
                            bits_seen <= 5'd0;
                            match_cnt <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
